wb_byte_loader: RTL and testbench

Stream-to-Wishbone byte writer sitting directly upstream of the 8-bit Wishbone RAM (`wb_ram_8x2k`). It accepts bytes on a valid/ready stream, buffers them in a small FIFO, and issues single Wishbone write cycles to consecutive RAM addresses from a programmable base. It tracks the byte count, address wrap and bus errors, and replaces the bench bus master as the RAM fill path, for example from a UART receive path.

---
 rtl/wb_byte_loader.sv | 155 +++++++++++++++
 tb/tb_wb_byte_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_loader.sv
// Stream-to-Wishbone byte writer: buffers bytes in a small FIFO and issues single
// write cycles to consecutive addresses starting at a programmable base.
`timescale 1ns/1ps
module wb_byte_loader #(
   parameter int unsigned ADDR_W     = 11,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [7:0]        s_data_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   output logic [ADDR_W-1:0] adr_o,
   output logic [7:0]        dat_o,
   output logic              we_o,
   output logic              cyc_o,
   output logic              stb_o,
   output logic              sel_o,
   input  logic              ack_i,
   input  logic              err_i,
   output logic [ADDR_W:0]   count_o,
   output logic              busy_o,
   output logic              wrap_o,
   output logic              err_o
);

   localparam int unsigned    PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HALT} state_t;

   state_t            r_state, w_state;
   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W:0]    r_wptr, r_rptr, w_wptr, w_rptr, w_level;
   logic [ADDR_W-1:0] r_addr, w_addr, r_adr, w_adr;
   logic [7:0]        r_dat, w_dat, r_tmo, w_tmo;
   logic [ADDR_W:0]   r_count, w_count;
   logic              r_ready, w_ready, r_stb, w_stb, r_busy, w_busy;
   logic              r_wrap, w_wrap, r_err, w_err;
   logic              w_push, w_empty, w_start;

   assign w_push  = s_valid_i & r_ready;
   assign w_empty = (r_wptr == r_rptr);
   assign w_start = start_i & (((r_state == S_IDLE) & w_empty) | (r_state == S_HALT));

   always_comb begin
      w_state = r_state;
      w_wptr  = w_push ? r_wptr + 1'b1 : r_wptr;
      w_rptr  = r_rptr;
      w_addr  = r_addr;
      w_tmo   = r_tmo;
      w_adr   = r_adr;
      w_dat   = r_dat;
      w_stb   = r_stb;
      w_count = r_count;
      w_wrap  = r_wrap;
      w_err   = r_err;
      if (w_start) begin
         // flush by moving the read pointer; a same-cycle push still lands at base
         w_rptr  = r_wptr;
         w_addr  = base_i;
         w_count = '0;
         w_wrap  = 1'b0;
         w_err   = 1'b0;
         w_state = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  w_adr   = r_addr;
                  w_dat   = r_mem[r_rptr[PTR_W-1:0]];
                  w_stb   = 1'b1;
                  w_tmo   = '0;
                  w_state = S_WRITE;
               end
            end
            S_WRITE: begin
               if (err_i || (r_tmo == TMO_LAST)) begin
                  w_rptr  = r_rptr + 1'b1;
                  w_stb   = 1'b0;
                  w_err   = 1'b1;
                  w_state = S_HALT;
               end else if (ack_i) begin
                  w_rptr  = r_rptr + 1'b1;
                  w_addr  = r_addr + 1'b1;
                  w_stb   = 1'b0;
                  w_state = S_IDLE;
                  if (r_addr == '1) w_wrap = 1'b1;
                  if (r_count != '1) w_count = r_count + 1'b1;
               end else begin
                  w_tmo = r_tmo + 1'b1;
               end
            end
            S_HALT:  w_state = S_HALT;
            default: w_state = S_IDLE;
         endcase
      end
      w_level = w_wptr - w_rptr;
      w_ready = (w_level != FULL_LVL) && (w_state != S_HALT);
      w_busy  = (w_level != '0) || (w_state == S_WRITE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_addr  <= '0;
         r_tmo   <= '0;
         r_adr   <= '0;
         r_dat   <= '0;
         r_stb   <= 1'b0;
         r_count <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_wptr  <= w_wptr;
         r_rptr  <= w_rptr;
         r_addr  <= w_addr;
         r_tmo   <= w_tmo;
         r_adr   <= w_adr;
         r_dat   <= w_dat;
         r_stb   <= w_stb;
         r_count <= w_count;
         r_ready <= w_ready;
         r_busy  <= w_busy;
         r_wrap  <= w_wrap;
         r_err   <= w_err;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= s_data_i;
   end

   assign s_ready_o = r_ready;
   assign adr_o     = r_adr;
   assign dat_o     = r_dat;
   assign we_o      = r_stb;
   assign cyc_o     = r_stb;
   assign stb_o     = r_stb;
   assign sel_o     = r_stb;
   assign count_o   = r_count;
   assign busy_o    = r_busy;
   assign wrap_o    = r_wrap;
   assign err_o     = r_err;

endmodule

// File: tb/tb_wb_byte_loader.sv
// Directed bench for wb_byte_loader: scoreboarded Wishbone slave with a RAM model,
// covering fill, backpressure, wrap, bus error, timeout and mid-cycle reset.
`timescale 1ns/1ps
module tb_wb_byte_loader;

   localparam int unsigned ADDR_W = 11;

   logic              clk = 1'b0;
   logic              rst_i, start_i, s_valid_i, s_ready_o;
   logic [ADDR_W-1:0] base_i, adr_o;
   logic [7:0]        s_data_i, dat_o;
   logic              we_o, cyc_o, stb_o, sel_o, ack_i, err_i;
   logic [ADDR_W:0]   count_o;
   logic              busy_o, wrap_o, err_o;

   wb_byte_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_i(base_i),
      .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
      .adr_o(adr_o), .dat_o(dat_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
      .sel_o(sel_o), .ack_i(ack_i), .err_i(err_i), .count_o(count_o),
      .busy_o(busy_o), .wrap_o(wrap_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] adr;
      logic [7:0]        dat;
   } exp_t;

   exp_t              sb[$];
   logic [7:0]        ram [2**ADDR_W];
   logic [ADDR_W-1:0] exp_addr;
   int                checks = 0;
   int                errors = 0;
   int                ack_dly = 1;
   bit                silent = 1'b0;
   int                err_at = 0;
   int                widx = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wishbone slave: checks each new cycle against the scoreboard, then acks/errs
   initial begin
      exp_t e;
      int   wcnt;
      wcnt  = 0;
      ack_i = 1'b0;
      err_i = 1'b0;
      forever begin
         @(negedge clk);
         ack_i = 1'b0;
         err_i = 1'b0;
         if (cyc_o && stb_o) begin
            if (wcnt == 0) begin
               widx++;
               chk("wb_we_sel", 32'({we_o, sel_o}), 32'd3);
               chk("wb_sb_nonempty", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("wb_adr", 32'(adr_o), 32'(e.adr));
                  chk("wb_dat", 32'(dat_o), 32'(e.dat));
               end
            end
            wcnt++;
            if (!silent && wcnt >= ack_dly) begin
               if (widx == err_at) err_i = 1'b1;
               else begin
                  ack_i = 1'b1;
                  ram[adr_o] = dat_o;
               end
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic push(input logic [7:0] d);
      int n = 0;
      s_data_i  = d;
      s_valid_i = 1'b1;
      while (!s_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("push_wait_bound", 32'(n < 200), 32'd1);
      @(posedge clk);
      sb.push_back(exp_t'({exp_addr, d}));
      exp_addr++;
      @(negedge clk);
      s_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drain"}, 32'(busy_o), 32'd0);
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b);
      start_i = 1'b1;
      base_i  = b;
      @(posedge clk);
      @(negedge clk);
      start_i  = 1'b0;
      exp_addr = b;
      sb.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] bp [6];
      int n;
      bp[0] = 8'h10; bp[1] = 8'h21; bp[2] = 8'h32;
      bp[3] = 8'h43; bp[4] = 8'h54; bp[5] = 8'h65;
      rst_i = 1'b1; start_i = 1'b0; base_i = '0; s_data_i = '0; s_valid_i = 1'b0;
      exp_addr = '0;
      repeat (3) @(negedge clk);

      chk("rst_ready", 32'(s_ready_o), 0);
      chk("rst_adr", 32'(adr_o), 0);
      chk("rst_dat", 32'(dat_o), 0);
      chk("rst_strobes", 32'({we_o, cyc_o, stb_o, sel_o}), 0);
      chk("rst_count", 32'(count_o), 0);
      chk("rst_flags", 32'({busy_o, wrap_o, err_o}), 0);
      rst_i = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(s_ready_o), 1);

      // address counter starts at 0 without a start pulse
      push(8'h77);
      wait_idle("rst_addr");
      chk("rst_addr_ram", 32'(ram[0]), 'h77);
      chk("rst_addr_count", 32'(count_o), 1);

      do_start(11'h010);
      chk("start_count_clr", 32'(count_o), 0);
      push(8'hA5); push(8'h5A); push(8'hC3);
      wait_idle("fill");
      chk("fill_ram0", 32'(ram[11'h010]), 'hA5);
      chk("fill_ram1", 32'(ram[11'h011]), 'h5A);
      chk("fill_ram2", 32'(ram[11'h012]), 'hC3);
      chk("fill_count", 32'(count_o), 3);
      chk("fill_flags", 32'({busy_o, wrap_o, err_o}), 0);

      ack_dly = 4;
      do_start(11'h200);
      for (int i = 0; i < 4; i++) push(bp[i]);
      chk("bp_ready_low", 32'(s_ready_o), 0);
      push(bp[4]); push(bp[5]);
      wait_idle("bp");
      for (int i = 0; i < 6; i++) chk("bp_ram", 32'(ram[11'h200 + 11'(i)]), 32'(bp[i]));
      chk("bp_count", 32'(count_o), 6);
      chk("bp_sb_empty", 32'(sb.size()), 0);

      ack_dly = 1;
      do_start(11'h7FE);
      push(8'h11); push(8'h22); push(8'h33);
      wait_idle("wrap");
      chk("wrap_ram_7fe", 32'(ram[11'h7FE]), 'h11);
      chk("wrap_ram_7ff", 32'(ram[11'h7FF]), 'h22);
      chk("wrap_ram_000", 32'(ram[11'h000]), 'h33);
      chk("wrap_flag", 32'(wrap_o), 1);
      chk("wrap_count", 32'(count_o), 3);

      do_start(11'h040);
      chk("start_wrap_clr", 32'(wrap_o), 0);
      err_at = widx + 2;
      push(8'h01); push(8'h02); push(8'h03);
      n = 0;
      while (!err_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("berr_err", 32'(err_o), 1);
      chk("berr_cyc", 32'(cyc_o), 0);
      chk("berr_ready", 32'(s_ready_o), 0);
      chk("berr_count", 32'(count_o), 1);
      chk("berr_ram", 32'(ram[11'h040]), 'h01);
      err_at = 0;
      do_start(11'h050);
      chk("berr_start_err", 32'(err_o), 0);
      chk("berr_start_count", 32'(count_o), 0);
      chk("berr_start_busy", 32'(busy_o), 0);
      chk("berr_start_ready", 32'(s_ready_o), 1);

      silent = 1'b1;
      do_start(11'h300);
      push(8'h99);
      n = 0;
      while (!stb_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (stb_o && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_stb_len", 32'(n), 8);
      chk("tmo_err", 32'(err_o), 1);
      chk("tmo_count", 32'(count_o), 0);

      do_start(11'h100);
      push(8'hB1); push(8'hB2); push(8'hB3);
      chk("mid_pre_stb", 32'(stb_o), 1);
      rst_i = 1'b1;
      @(negedge clk);
      chk("mid_strobes", 32'({we_o, cyc_o, stb_o, sel_o}), 0);
      chk("mid_count", 32'(count_o), 0);
      chk("mid_busy", 32'(busy_o), 0);
      rst_i    = 1'b0;
      silent   = 1'b0;
      exp_addr = '0;
      sb.delete();
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (cyc_o) n++;
      end
      chk("mid_no_activity", 32'(n), 0);
      chk("mid_ready", 32'(s_ready_o), 1);
      push(8'hEE);
      wait_idle("mid_new");
      chk("mid_new_ram", 32'(ram[0]), 'hEE);
      chk("mid_new_count", 32'(count_o), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
